// File: rtl/wishbone_master_if.sv
// -----------------------------------------------------------------------------
// wishbone_master_if
//
// Purpose : Wishbone classic-cycle bus bundle for one master port.
//
// Signals (named from the bus point of view, master drives the first group):
//   master -> slave : dat_w[31:0] write data, adr[31:0] byte address,
//                     sel[3:0] byte lanes, we write enable, cyc cycle active,
//                     stb strobe, lock bus lock, tga/tgd_w/tgc address,
//                     write-data and cycle tags (TAGSIZE bits each)
//   slave -> master : dat_r[31:0] read data, tgd_r read-data tag,
//                     ack / err / rty terminations, gnt grant from the
//                     interconnect arbiter
// -----------------------------------------------------------------------------
interface wishbone_master_if #(
   parameter int TAGSIZE = 1
);
   logic [31:0]        dat_w;
   logic [31:0]        adr;
   logic [3:0]         sel;
   logic               we;
   logic               cyc;
   logic               stb;
   logic               lock;
   logic [TAGSIZE-1:0] tga;
   logic [TAGSIZE-1:0] tgd_w;
   logic [TAGSIZE-1:0] tgc;
   logic [31:0]        dat_r;
   logic [TAGSIZE-1:0] tgd_r;
   logic               ack;
   logic               err;
   logic               rty;
   logic               gnt;

   modport master (
      output dat_w, adr, sel, we, cyc, stb, lock, tga, tgd_w, tgc,
      input  dat_r, tgd_r, ack, err, rty, gnt
   );

   modport slave (
      input  dat_w, adr, sel, we, cyc, stb, lock, tga, tgd_w, tgc,
      output dat_r, tgd_r, ack, err, rty, gnt
   );
endinterface

// File: rtl/wishbone_master.sv
// -----------------------------------------------------------------------------
// wishbone_master
//
// Purpose : Wishbone classic-cycle initiator. Turns a single-beat core
//           request/response pair into master signalling on one port of the
//           shared interconnect. Handles arbitration wait, retry back-off,
//           a response timeout and bus locking across back-to-back accesses.
//
// Parameters:
//   TAGSIZE   width of the tga/tgd/tgc tags
//   MAX_RETRY rty terminations tolerated per request (1..15)
//   TIMEOUT   XFER cycles without ack/err/rty before abort (1..255)
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_i / ready_o   core request handshake
//   we_i, adr_i, dat_i, sel_i, tag_i, lock_i   request payload
//   valid_o           one-cycle response strobe
//   rdata_o, resp_o   read data and status (0 OK, 1 ERR,
//                     2 RETRY_EXHAUSTED, 3 TIMEOUT), valid with valid_o
//   dbg_state         current FSM state, for observation only
//   wb                Wishbone master modport
// -----------------------------------------------------------------------------
module wishbone_master #(
   parameter int TAGSIZE   = 1,
   parameter int MAX_RETRY = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic               clk_i,
   input  logic               rst_i,

   // Core request side
   input  logic               req_i,
   output logic               ready_o,
   input  logic               we_i,
   input  logic [31:0]        adr_i,
   input  logic [31:0]        dat_i,
   input  logic [3:0]         sel_i,
   input  logic [TAGSIZE-1:0] tag_i,
   input  logic               lock_i,

   // Core response side
   output logic               valid_o,
   output logic [31:0]        rdata_o,
   output logic [1:0]         resp_o,

   output logic [2:0]         dbg_state,

   wishbone_master_if.master  wb
);

   // Core handshake: a request transfers on a rising clk_i edge where both
   // req_i and ready_o are high. ready_o is high only in IDLE, so exactly one
   // request is outstanding at a time; its single response is the cycle in
   // which valid_o is high, and that strobe cannot be back-pressured.

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARB     = 3'd1;
   localparam logic [2:0] S_XFER    = 3'd2;
   localparam logic [2:0] S_BACKOFF = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   localparam logic [1:0] RESP_OK   = 2'd0;
   localparam logic [1:0] RESP_ERR  = 2'd1;
   localparam logic [1:0] RESP_RTY  = 2'd2;
   localparam logic [1:0] RESP_TMO  = 2'd3;

   localparam logic [3:0] RETRY_LIMIT  = 4'(MAX_RETRY);
   // The counter holds the number of XFER cycles already completed, so the
   // abort fires during the TIMEOUT-th strobe cycle.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [2:0]         state;
   logic [2:0]         state_nxt;

   // Request captured at acceptance
   logic [31:0]        adr_q;
   logic [31:0]        dat_q;
   logic [3:0]         sel_q;
   logic               we_q;
   logic [TAGSIZE-1:0] tag_q;
   logic               lock_q;

   // Bus ownership kept across IDLE after a locked access
   logic               lock_flag;

   logic [3:0]         retry_cnt;
   logic [7:0]         tmo_cnt;

   logic [31:0]        rdata_q;
   logic [1:0]         resp_q;

   logic               accept;
   logic               in_cycle;
   logic               retry_last;
   logic               tmo_last;

   // The read-data tag carries no meaning for this initiator.
   logic               unused_tgd;
   assign unused_tgd = ^wb.tgd_r;

   assign ready_o    = (state == S_IDLE) & ~rst_i;
   assign accept     = req_i & ready_o;
   assign retry_last = ((retry_cnt + 4'd1) == RETRY_LIMIT);
   assign tmo_last   = (tmo_cnt == TIMEOUT_LAST);
   assign in_cycle   = (state == S_ARB) | (state == S_XFER) |
                       (state == S_BACKOFF);

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               // A held bus with grant still present needs no re-arbitration.
               state_nxt = (lock_flag & wb.gnt) ? S_XFER : S_ARB;
            end
         end
         S_ARB: begin
            if (wb.gnt) begin
               state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            // Terminations win over a grant loss seen in the same cycle:
            // the slave has already completed or refused the access.
            if (wb.ack | wb.err) begin
               state_nxt = S_RESP;
            end else if (wb.rty) begin
               state_nxt = retry_last ? S_RESP : S_BACKOFF;
            end else if (!wb.gnt) begin
               state_nxt = S_ARB;
            end else if (tmo_last) begin
               state_nxt = S_RESP;
            end
         end
         S_BACKOFF: begin
            state_nxt = S_XFER;
         end
         S_RESP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State, captured request, counters and response registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         tag_q     <= '0;
         lock_q    <= 1'b0;
         lock_flag <= 1'b0;
         retry_cnt <= '0;
         tmo_cnt   <= '0;
         rdata_q   <= '0;
         resp_q    <= RESP_OK;
      end else begin
         state <= state_nxt;

         if (accept) begin
            adr_q  <= adr_i;
            dat_q  <= dat_i;
            sel_q  <= sel_i;
            we_q   <= we_i;
            tag_q  <= tag_i;
            lock_q <= lock_i;
         end

         case (state)
            S_XFER: begin
               if (wb.ack) begin
                  rdata_q <= we_q ? 32'h0 : wb.dat_r;
                  resp_q  <= RESP_OK;
               end else if (wb.err) begin
                  resp_q <= RESP_ERR;
               end else if (wb.rty) begin
                  retry_cnt <= retry_cnt + 4'd1;
                  tmo_cnt   <= '0;
                  if (retry_last) begin
                     resp_q <= RESP_RTY;
                  end
               end else if (!wb.gnt) begin
                  // Grant lost: the access restarts from arbitration with a
                  // fresh timeout budget but the same retry history.
                  tmo_cnt <= '0;
               end else if (tmo_last) begin
                  resp_q <= RESP_TMO;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            S_RESP: begin
               // The lock of the access just finished decides whether the
               // bus is kept for the next one.
               lock_flag <= lock_q;
               retry_cnt <= '0;
               tmo_cnt   <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs, decoded from registered state so reset removes them at once
   // --------------------------------------------------------------------------
   always_comb begin
      wb.cyc   = in_cycle |
                 ((state == S_RESP) & lock_q) |
                 ((state == S_IDLE) & lock_flag);
      wb.stb   = (state == S_XFER);
      // An unlocking access that runs on a held bus keeps lock asserted
      // until its own RESP releases it.
      wb.lock  = (in_cycle & (lock_q | lock_flag)) |
                 ((state == S_RESP) & lock_q) |
                 ((state == S_IDLE) & lock_flag);
      wb.we    = in_cycle & we_q;
      wb.sel   = in_cycle ? sel_q : 4'h0;
      wb.dat_w = in_cycle ? dat_q : 32'h0;
      wb.adr   = adr_q;
      wb.tga   = tag_q;
      wb.tgd_w = tag_q;
      wb.tgc   = tag_q;
   end

   assign valid_o   = (state == S_RESP);
   assign rdata_o   = rdata_q;
   assign resp_o    = resp_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_wishbone_master.sv
// -----------------------------------------------------------------------------
// tb_wishbone_master
//
// Table of request records applied through a reactive Wishbone slave model,
// plus hand-written sequences for locked back-to-back access and reset during
// a transfer. Expected responses are queued when a request is driven and
// compared when valid_o fires.
// -----------------------------------------------------------------------------
module tb_wishbone_master;

   localparam int TAGSIZE   = 1;
   localparam int MAX_RETRY = 4;
   localparam int TIMEOUT   = 255;

   localparam int FIN_ACK    = 0;
   localparam int FIN_ERR    = 1;
   localparam int FIN_SILENT = 2;
   localparam int FIN_ACKRTY = 3;

   // --------------------------------------------------------------------------
   // Clock / reset
   // --------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic               req;
   logic               ready;
   logic               we;
   logic [31:0]        adr;
   logic [31:0]        dat;
   logic [3:0]         sel;
   logic [TAGSIZE-1:0] tag;
   logic               lock;
   logic               valid;
   logic [31:0]        rdata;
   logic [1:0]         resp;
   logic [2:0]         dbg_state;

   wishbone_master_if #(.TAGSIZE(TAGSIZE)) wb_bus ();

   wishbone_master #(
      .TAGSIZE  (TAGSIZE),
      .MAX_RETRY(MAX_RETRY),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .ready_o  (ready),
      .we_i     (we),
      .adr_i    (adr),
      .dat_i    (dat),
      .sel_i    (sel),
      .tag_i    (tag),
      .lock_i   (lock),
      .valid_o  (valid),
      .rdata_o  (rdata),
      .resp_o   (resp),
      .dbg_state(dbg_state),
      .wb       (wb_bus)
   );

   // --------------------------------------------------------------------------
   // Vector records and scoreboard
   // --------------------------------------------------------------------------
   typedef struct {
      logic               we;
      logic [31:0]        adr;
      logic [31:0]        dat;
      logic [3:0]         sel;
      logic [TAGSIZE-1:0] tag;
      logic               lock;
      int                 gnt_start;  // grant high from this cycle index on
      int                 gnt_drop;   // grant low in this one cycle (-1 none)
      int                 waits;      // wait states before each termination
      int                 n_rty;      // rty terminations before the final one
      int                 fin;        // final termination kind
      logic [31:0]        rdat;
      logic [1:0]         exp_resp;
      int                 exp_stb;    // strobe cycles
      int                 exp_bo;     // cyc-only cycles after the first strobe
      int                 exp_lat;    // cycle index of valid_o after accept
   } vec_t;

   logic [33:0] exp_q[$];
   logic [31:0] last_rdata = 32'h0;
   int          n_checks   = 0;
   int          n_pass     = 0;

   function automatic vec_t mk(input logic we_v, input logic [31:0] adr_v,
                               input logic [31:0] dat_v, input logic [3:0] sel_v,
                               input logic lock_v, input int gs, input int gd,
                               input int w, input int nr, input int fin,
                               input logic [31:0] rdat_v, input logic [1:0] er,
                               input int es, input int eb, input int el);
      vec_t v;
      v.we = we_v; v.adr = adr_v; v.dat = dat_v; v.sel = sel_v;
      v.tag = adr_v[TAGSIZE+1:2]; v.lock = lock_v;
      v.gnt_start = gs; v.gnt_drop = gd; v.waits = w; v.n_rty = nr;
      v.fin = fin; v.rdat = rdat_v; v.exp_resp = er;
      v.exp_stb = es; v.exp_bo = eb; v.exp_lat = el;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // --------------------------------------------------------------------------
   // Driver + reactive slave for one transaction. Entered and left #1 after a
   // rising edge with the DUT in IDLE. Cycle index k counts edges after the
   // accepting one.
   // --------------------------------------------------------------------------
   task automatic run_txn(input vec_t v);
      int          k = 0;
      int          stb_n = 0;
      int          bo_n = 0;
      int          wcnt = 0;
      int          rty_n = 0;
      bit          seen_stb = 0;
      bit          done = 0;
      logic        prev_gnt;
      logic [33:0] e;

      check("ready_before_req", ready, 1);
      req = 1; we = v.we; adr = v.adr; dat = v.dat; sel = v.sel;
      tag = v.tag; lock = v.lock;
      wb_bus.gnt = (v.gnt_start == 0);
      wb_bus.ack = 0; wb_bus.err = 0; wb_bus.rty = 0;
      if ((v.fin == FIN_ACK || v.fin == FIN_ACKRTY) && v.n_rty < MAX_RETRY)
         last_rdata = v.we ? 32'h0 : v.rdat;
      exp_q.push_back({v.exp_resp, last_rdata});

      while (!done) begin
         @(posedge clk); #1;
         k++;
         req = 0;
         wb_bus.ack = 0; wb_bus.err = 0; wb_bus.rty = 0;
         prev_gnt   = wb_bus.gnt;
         wb_bus.gnt = (k >= v.gnt_start) && (k != v.gnt_drop);
         if (k > 2000) begin
            check("txn_bound", 0, 1);
            done = 1;
         end else if (valid) begin
            if (exp_q.size() == 0) begin
               check("sb_nonempty", 0, 1);
            end else begin
               e = exp_q.pop_front();
               check("resp", {30'h0, resp}, {30'h0, e[33:32]});
               check("rdata", rdata, e[31:0]);
            end
            check("stb_cycles", stb_n, v.exp_stb);
            check("backoff_cycles", bo_n, v.exp_bo);
            check("latency", k, v.exp_lat);
            check("resp_stb_low", wb_bus.stb, 0);
            check("resp_cyc", wb_bus.cyc, v.lock);
            check("resp_lock", wb_bus.lock, v.lock);
            done = 1;
         end else if (wb_bus.stb) begin
            if (!seen_stb) begin
               seen_stb = 1;
               check("stb_after_gnt", prev_gnt, 1);
               check("bus_adr", wb_bus.adr, v.adr);
               check("bus_we", wb_bus.we, v.we);
               check("bus_sel", {28'h0, wb_bus.sel}, {28'h0, v.sel});
               check("bus_dat", wb_bus.dat_w, v.dat);
               check("bus_tga", 32'(wb_bus.tga), 32'(v.tag));
            end
            stb_n++;
            if (wb_bus.gnt) begin
               if (wcnt < v.waits) begin
                  wcnt++;
               end else begin
                  wcnt = 0;
                  if (rty_n < v.n_rty) begin
                     wb_bus.rty = 1;
                     rty_n++;
                  end else if (v.fin == FIN_ACK) begin
                     wb_bus.ack = 1; wb_bus.dat_r = v.rdat;
                  end else if (v.fin == FIN_ERR) begin
                     wb_bus.err = 1;
                  end else if (v.fin == FIN_ACKRTY) begin
                     wb_bus.ack = 1; wb_bus.rty = 1; wb_bus.dat_r = v.rdat;
                  end
               end
            end
         end else if (seen_stb && wb_bus.cyc) begin
            bo_n++;
         end
      end

      wb_bus.ack = 0; wb_bus.err = 0; wb_bus.rty = 0;
      @(posedge clk); #1;
      check("valid_one_cycle", valid, 0);
      check("ready_after", ready, 1);
      check("idle_cyc", wb_bus.cyc, v.lock);
      check("idle_lock", wb_bus.lock, v.lock);
      if (!v.lock) wb_bus.gnt = 0;
   endtask

   // --------------------------------------------------------------------------
   // Test sequence
   // --------------------------------------------------------------------------
   vec_t vecs[9];
   vec_t rv;
   vec_t lk1, lk2;

   initial begin
      req = 0; we = 0; adr = 0; dat = 0; sel = 0; tag = 0; lock = 0;
      wb_bus.dat_r = 0; wb_bus.tgd_r = 0;
      wb_bus.ack = 0; wb_bus.err = 0; wb_bus.rty = 0; wb_bus.gnt = 0;

      //            we adr          dat          sel  lk gs gd  w nr fin         rdat          rsp stb bo  lat
      vecs[0] = mk(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 1, -1, 0, 0, FIN_ACK,    32'h0,        0, 1,   0, 3);
      vecs[1] = mk(0, 32'h2004, 32'h0,        4'hF, 0, 6, -1, 3, 0, FIN_ACK,    32'h12345678, 0, 4,   0, 11);
      vecs[2] = mk(0, 32'h3008, 32'h0,        4'h3, 0, 1, -1, 0, 2, FIN_ACK,    32'hA5A50001, 0, 3,   2, 7);
      vecs[3] = mk(1, 32'h300C, 32'h11112222, 4'hC, 0, 1, -1, 0, 4, FIN_ACK,    32'h0,        2, 4,   3, 9);
      vecs[4] = mk(0, 32'h4010, 32'h0,        4'hF, 0, 1, -1, 0, 0, FIN_ACKRTY, 32'h0BADF00D, 0, 1,   0, 3);
      vecs[5] = mk(0, 32'h5014, 32'h0,        4'hF, 0, 1, -1, 0, 0, FIN_SILENT, 32'h0,        3, 255, 0, 257);
      vecs[6] = mk(1, 32'h6018, 32'hCAFEF00D, 4'h1, 0, 1, -1, 0, 0, FIN_ERR,    32'h0,        1, 1,   0, 3);
      vecs[7] = mk(0, 32'h701C, 32'h0,        4'hF, 0, 1, -1, 1, 1, FIN_ERR,    32'h0,        1, 4,   1, 7);
      vecs[8] = mk(0, 32'h8020, 32'h0,        4'hF, 0, 1,  3, 2, 0, FIN_ACK,    32'h600DF00D, 0, 4,   1, 7);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 0);
      check("rst_valid", valid, 0);
      check("rst_cyc", wb_bus.cyc, 0);
      check("rst_stb", wb_bus.stb, 0);
      check("rst_lock", wb_bus.lock, 0);
      check("rst_adr", wb_bus.adr, 0);
      check("rst_rdata", rdata, 0);
      check("rst_state", 32'(dbg_state), 0);
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;
      check("ready_after_rst", ready, 1);

      // Table-driven records
      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // Randomised acked accesses
      for (int i = 0; i < 4; i++) begin
         rv = mk($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom,
                 4'($urandom_range(1, 15)), 0, $urandom_range(1, 4), -1,
                 $urandom_range(0, 3), $urandom_range(0, 2), FIN_ACK,
                 $urandom, 0, 0, 0, 0);
         rv.exp_stb = (rv.n_rty + 1) * (rv.waits + 1);
         rv.exp_bo  = rv.n_rty;
         rv.exp_lat = rv.gnt_start + 1 + rv.exp_stb + rv.exp_bo;
         run_txn(rv);
      end

      // Locked back-to-back: the second access rides the held bus
      lk1 = mk(1, 32'h9000, 32'h01020304, 4'hF, 1, 1, -1, 0, 0, FIN_ACK, 32'h0,        0, 1, 0, 3);
      lk2 = mk(0, 32'h9004, 32'h0,        4'hF, 0, 0, -1, 0, 0, FIN_ACK, 32'h77778888, 0, 1, 0, 2);
      run_txn(lk1);
      check("locked_gap_cyc", wb_bus.cyc, 1);
      check("locked_gap_stb", wb_bus.stb, 0);
      run_txn(lk2);

      // Reset while the slave stalls in XFER
      req = 1; we = 0; adr = 32'hA000; sel = 4'hF; lock = 0; wb_bus.gnt = 1;
      @(posedge clk); #1;
      req = 0;
      for (int i = 0; i < 10 && !wb_bus.stb; i++) begin
         @(posedge clk); #1;
      end
      check("reached_xfer", wb_bus.stb, 1);
      repeat (3) @(posedge clk);
      #3;
      rst = 1;
      #1;
      check("async_rst_cyc", wb_bus.cyc, 0);
      check("async_rst_stb", wb_bus.stb, 0);
      check("async_rst_valid", valid, 0);
      wb_bus.gnt = 0;
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;
      check("ready_after_mid_rst", ready, 1);
      check("no_resp_after_rst", valid, 0);
      run_txn(vecs[0]);

      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wishbone_master.md
Name: wishbone_master

Overview:
- Wishbone classic-cycle initiator: converts a simple single-beat core request/response interface into Wishbone master signalling.
- Drives one master port of the shared Wishbone interconnect and consumes its grant, ack, err and rty responses.
- Owns arbitration wait, retry back-off, a response timeout and bus locking for back-to-back accesses.

Parameters:
- TAGSIZE, 1, width of tga/tgd/tgc tags.
- MAX_RETRY, 4, rty responses tolerated per request before it is abandoned; 1..15.
- TIMEOUT, 255, XFER cycles without ack/err/rty before abort; 1..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  async reset, active-high.
- req_i  in  1  core request valid.
- ready_o  out  1  request accepted when req_i & ready_o.
- we_i  in  1  1=write.
- adr_i  in  32  byte address.
- dat_i  in  32  write data.
- sel_i  in  4  byte lanes.
- tag_i  in  TAGSIZE  driven on tga/tgd/tgc.
- lock_i  in  1  keep bus after this access.
- valid_o  out  1  one-cycle response strobe.
- rdata_o  out  32  read data; valid with valid_o.
- resp_o  out  2  0=OK, 1=ERR, 2=RETRY_EXHAUSTED, 3=TIMEOUT.
- wb_dat_o  out  32  write data to bus.
- wb_adr_o  out  32  address.
- wb_sel_o  out  4  byte select.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle in progress.
- wb_stb_o  out  1  strobe.
- wb_lock_o  out  1  lock request.
- wb_tga_o, wb_tgd_o, wb_tgc_o  out  TAGSIZE each  tags.
- wb_dat_i  in  32  read data.
- wb_tgd_i  in  TAGSIZE  ignored.
- wb_ack_i  in  1  ack.
- wb_err_i  in  1  error.
- wb_rty_i  in  1  retry.
- wb_gnt_i  in  1  bus grant from interconnect.

Behaviour:
- Reset: all outputs 0.
  - State IDLE; counters 0; lock flag 0.
  - Reset mid-transaction drops cyc/stb immediately; no response is issued.
- ready_o = (state==IDLE).
- Acceptance registers adr, dat, sel, we, tag and lock_i. These drive wb_* outputs until the next acceptance.
  - wb_we_o, wb_sel_o and wb_dat_o are 0 outside ARB/XFER/BACKOFF.
- States:
  - IDLE:
    - On accept: if lock flag set and wb_gnt_i=1, go to XFER; else go to ARB.
  - ARB:
    - wb_cyc_o=1, wb_stb_o=0.
    - On wb_gnt_i=1, go to XFER next cycle.
    - No timeout in ARB.
  - XFER:
    - wb_cyc_o=1, wb_stb_o=1; timeout counter increments each cycle.
    - Response priority when asserted together: ack > err > rty.
    - ack: capture wb_dat_i into rdata_o for reads (rdata_o=0 for writes); resp=0; go to RESP.
    - err: resp=1; go to RESP.
    - rty:
      - Increment retry count.
      - If count == MAX_RETRY: resp=2, go to RESP.
      - Else go to BACKOFF; timeout counter cleared.
    - Timeout counter reaching TIMEOUT with no response: resp=3, go to RESP.
    - wb_gnt_i=0 while in XFER: drop stb, go to ARB. Retry count unchanged; timeout counter cleared.
  - BACKOFF:
    - One cycle with wb_cyc_o=1, wb_stb_o=0, then XFER.
  - RESP:
    - valid_o=1 for exactly one cycle, with rdata_o/resp_o.
    - wb_stb_o=0.
    - wb_cyc_o and wb_lock_o stay 1 only if captured lock=1; otherwise 0.
    - Go to IDLE; retry and timeout counters cleared.
- Locked bus:
  - While lock flag=1, wb_cyc_o and wb_lock_o remain 1 through IDLE.
  - A following request whose lock_i=0 clears the lock flag when it reaches RESP.
- Latency:
  - Unlocked, immediate grant, zero-wait ack: accept at T0; ARB at T1; XFER at T2 (ack seen); valid_o at T3.
- rdata_o holds its value until the next ack.
- Counter widths: 4-bit retry, 8-bit timeout; neither wraps, both clear on exit.

Test Plan:
- Write adr=0x1000, dat=0xDEADBEEF, sel=0xF; gnt immediate; ack in 1st XFER cycle -> wb_stb_o high exactly 1 cycle, valid_o at T3, resp_o=0.
- Read adr=0x2004; gnt delayed 5 cycles; 3 wait states then ack with wb_dat_i=0x12345678 -> stb rises only after gnt, rdata_o=0x12345678, resp_o=0.
- Two rty then ack (MAX_RETRY=4) -> two BACKOFF cycles with stb=0 and cyc=1, final resp_o=0; four rty -> resp_o=2, no 5th stb; ack+rty same cycle -> resp_o=0.
- Slave silent -> stb high exactly 255 cycles, then resp_o=3 with valid_o; err response -> resp_o=1.
- Locked back-to-back: 1st req lock_i=1, 2nd lock_i=0 -> cyc stays high between accesses, 2nd skips ARB, cyc and lock drop after 2nd RESP.
- rst_i asserted in XFER -> cyc/stb/valid_o=0 asynchronously, ready_o=1 after release, next request completes normally.
